mux_tdm_81: RTL and testbench
=============================

# mux_tdm_81

Sequential 8-to-1 time-division multiplexer: the transmit end of the 8-line select/demux path. When enabled, it snapshots eight parallel input lines once per frame and sends them one per slot on a single serial line `y`. Alongside each bit it drives the slot index on `s1`/`s2`/`s3`, so a downstream 1-to-8 demux can steer every bit back to its own line. It sits between the parallel source lines and the serial link feeding the demux stage.

## Interface
Parameters:
- SLOT_CYCLES, 1, clock cycles each slot is held on the link; legal range 1..16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  frame request; sampled only at frame boundaries.
- I0..I7  input  1 each  parallel data lines; captured into a shadow register at frame start.
- y  output  1  serial data bit for the current slot.
- s1  output  1  slot index bit 0 (LSB).
- s2  output  1  slot index bit 1.
- s3  output  1  slot index bit 2 (MSB).
- valid  output  1  high while `y`/`s1..s3` carry a frame slot.
- frame_sync  output  1  high for the whole of slot 0 of each frame.
- frame_done  output  1  one-cycle pulse after slot 7 of each frame has been fully held.

## Operation
- Clock, reset and polarity are fixed: one clock `clk`; reset `reset` is asynchronous and active-high.
- Internal state:
  - two-state FSM, IDLE and RUN;
  - 8-bit shadow register;
  - 3-bit slot counter;
  - 4-bit hold counter, counting 0..SLOT_CYCLES-1.
- Reset (asynchronous, any time, including mid-frame):
  - FSM goes to IDLE; shadow, slot and hold counters go to 0.
  - y=0, s1=s2=s3=0, valid=0, frame_sync=0, frame_done=0.
  - The partial frame is discarded; nothing resumes after reset is released.
- IDLE, on an edge with enable=1:
  - shadow <= {I7..I0}; slot <= 0; hold <= 0; go to RUN.
  - Registered outputs: y=I0, s=000, valid=1, frame_sync=1.
- IDLE, on an edge with enable=0: stay in IDLE; outputs hold their reset values.
- RUN, hold < SLOT_CYCLES-1: increment hold; all outputs unchanged.
- RUN, hold = SLOT_CYCLES-1 and slot < 7:
  - slot increments, hold <= 0.
  - y <= shadow[slot+1]; s1..s3 <= slot+1; frame_sync <= 0.
- RUN, hold = SLOT_CYCLES-1 and slot = 7 (frame boundary):
  - frame_done <= 1 for one cycle.
  - enable=1: recapture the I lines into shadow and restart at slot 0 with frame_sync=1. Frames run back-to-back with no idle gap.
  - enable=0: go to IDLE; y, s and valid return to 0.
- Mid-frame behaviour:
  - Changes on I0..I7 have no effect until the next capture.
  - Deasserting enable mid-frame does not truncate the frame; it always completes all 8 slots.
- Slot order is fixed at 0,1,...,7; s3:s2:s1 = slot in binary.

## Timing
- All outputs are registered.
- Latency from enable sampled high in IDLE to the first valid bit: 1 cycle, with I0 on y.
- Frame length: 8×SLOT_CYCLES cycles. valid stays high continuously across back-to-back frames.
- frame_done is high in the first cycle of the next frame, or in the first IDLE cycle. It coincides with frame_sync when frames are back-to-back.
- With SLOT_CYCLES=1, y changes every cycle and slot wraps 7→0 without a bubble.

## Test plan
- Reset mid-frame: SLOT_CYCLES=1, I=8'hA5, enable=1; assert reset during slot 3 -> all outputs 0 immediately, asynchronously. After release with enable=0, FSM stays IDLE with valid=0.
- Single frame: SLOT_CYCLES=1, I7..I0=8'b1010_0101; enable pulsed high for one cycle -> y sequence 1,0,1,0,0,1,0,1 for slots 0..7. s1..s3 count 000..111. frame_sync only in slot 0. frame_done one cycle after slot 7, then valid=0.
- Back-to-back frames: enable held high, I=8'hFF for frame 1; change I to 8'h00 during slot 4 -> frame 1 sends all 1s, frame 2 sends all 0s. There is no valid gap, and frame_done coincides with the second frame_sync.
- Hold cycles: SLOT_CYCLES=3, I=8'h0F -> each slot lasts exactly 3 cycles. y=1 for 12 cycles, then y=0 for 12 cycles. frame_done arrives 24 cycles after the first valid cycle.
- Late disable: SLOT_CYCLES=2; enable dropped in slot 2 -> the frame completes all 8 slots, then returns to IDLE with y=0, s=000, valid=0.
- Demux loopback: connect y/s1..s3 to the 8-line demux with its enable=1, I=8'h3C -> demux output line k carries bit k of 8'h3C during slot k.

Source files
------------

// File: rtl/mux_tdm_81.sv
// Transmit side of the 8-line TDM link: snapshots I0..I7 at each frame start and
// serialises them one slot at a time, tagging every bit with its slot index.
module mux_tdm_81 #(
  parameter int unsigned SLOT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  input  logic I4,
  input  logic I5,
  input  logic I6,
  input  logic I7,
  output logic y,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic valid,
  output logic frame_sync,
  output logic frame_done
);

  localparam logic       IDLE     = 1'b0;
  localparam logic       RUN      = 1'b1;
  localparam logic [3:0] HOLD_MAX = 4'(SLOT_CYCLES - 1);

  logic       state_q,  state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] slot_q,   slot_d;
  logic [3:0] hold_q,   hold_d;
  logic       y_q,      y_d;
  logic       valid_q,  valid_d;
  logic       sync_q,   sync_d;
  logic       done_q,   done_d;

  logic [7:0] inLines;
  logic [2:0] slotNext;
  logic       slotEnd;
  logic       frameEnd;
  logic       startFrame;

  assign inLines    = {I7, I6, I5, I4, I3, I2, I1, I0};
  assign slotNext   = slot_q + 3'd1;
  assign slotEnd    = (state_q == RUN) && (hold_q == HOLD_MAX);
  assign frameEnd   = slotEnd && (slot_q == 3'd7);
  // enable only matters at a frame boundary: in IDLE or at the end of slot 7
  assign startFrame = enable && ((state_q == IDLE) || frameEnd);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    slot_d   = slot_q;
    hold_d   = hold_q;
    y_d      = y_q;
    valid_d  = valid_q;
    sync_d   = sync_q;
    done_d   = 1'b0;

    if (frameEnd) begin
      done_d = 1'b1;
    end

    if (startFrame) begin
      state_d  = RUN;
      shadow_d = inLines;
      slot_d   = 3'd0;
      hold_d   = 4'd0;
      y_d      = inLines[0];
      valid_d  = 1'b1;
      sync_d   = 1'b1;
    end else if (frameEnd) begin
      state_d = IDLE;
      slot_d  = 3'd0;
      hold_d  = 4'd0;
      y_d     = 1'b0;
      valid_d = 1'b0;
      sync_d  = 1'b0;
    end else if (slotEnd) begin
      slot_d = slotNext;
      hold_d = 4'd0;
      y_d    = shadow_q[slotNext];
      sync_d = 1'b0;
    end else if (state_q == RUN) begin
      hold_d = hold_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= 8'd0;
      slot_q   <= 3'd0;
      hold_q   <= 4'd0;
      y_q      <= 1'b0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      slot_q   <= slot_d;
      hold_q   <= hold_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      sync_q   <= sync_d;
      done_q   <= done_d;
    end
  end

  // slot_q is forced to 0 outside a frame, so it drives the index lines directly
  assign y          = y_q;
  assign s1         = slot_q[0];
  assign s2         = slot_q[1];
  assign s3         = slot_q[2];
  assign valid      = valid_q;
  assign frame_sync = sync_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_mux_tdm_81.sv
// Scoreboard bench: three instances (SLOT_CYCLES 1, 2, 3) share stimulus; a frame-level
// model pushes the expected slot stream per frame and a negedge monitor pops it.
module tb_mux_tdm_81;

  typedef struct packed {
    logic       y;
    logic [2:0] s;
    logic       sync;
    logic       last;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] lines;

  logic [2:0] yOut, s1Out, s2Out, s3Out, validOut, syncOut, doneOut;

  exp_t expQ[3][$];
  logic expDone[3];
  logic running[3];
  int   left[3];

  int checks   = 0;
  int failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mux_tdm_81 #(.SLOT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable),
    .I0(lines[0]), .I1(lines[1]), .I2(lines[2]), .I3(lines[3]),
    .I4(lines[4]), .I5(lines[5]), .I6(lines[6]), .I7(lines[7]),
    .y(yOut[0]), .s1(s1Out[0]), .s2(s2Out[0]), .s3(s3Out[0]),
    .valid(validOut[0]), .frame_sync(syncOut[0]), .frame_done(doneOut[0])
  );

  mux_tdm_81 #(.SLOT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .I0(lines[0]), .I1(lines[1]), .I2(lines[2]), .I3(lines[3]),
    .I4(lines[4]), .I5(lines[5]), .I6(lines[6]), .I7(lines[7]),
    .y(yOut[1]), .s1(s1Out[1]), .s2(s2Out[1]), .s3(s3Out[1]),
    .valid(validOut[1]), .frame_sync(syncOut[1]), .frame_done(doneOut[1])
  );

  mux_tdm_81 #(.SLOT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable),
    .I0(lines[0]), .I1(lines[1]), .I2(lines[2]), .I3(lines[3]),
    .I4(lines[4]), .I5(lines[5]), .I6(lines[6]), .I7(lines[7]),
    .y(yOut[2]), .s1(s1Out[2]), .s2(s2Out[2]), .s3(s3Out[2]),
    .valid(validOut[2]), .frame_sync(syncOut[2]), .frame_done(doneOut[2])
  );

  function automatic int slotCycles(input int d);
    return d + 1;
  endfunction

  task automatic checkOutput(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] data);
    enable = en;
    lines  = data;
  endtask

  // Frame-level model: at each frame boundary, either capture and queue the whole frame or go idle
  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        expQ[d].delete();
        running[d] = 1'b0;
        left[d]    = 0;
      end else if (!running[d] || left[d] == 1) begin
        if (enable) begin
          for (int k = 0; k < 8; k++) begin
            for (int h = 0; h < slotCycles(d); h++) begin
              exp_t e;
              e.y    = lines[k];
              e.s    = 3'(k);
              e.sync = (k == 0);
              e.last = (k == 7) && (h == slotCycles(d) - 1);
              expQ[d].push_back(e);
            end
          end
          running[d] = 1'b1;
          left[d]    = 8 * slotCycles(d);
        end else begin
          running[d] = 1'b0;
          left[d]    = 0;
        end
      end else begin
        left[d] = left[d] - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic [2:0] sAct;
      exp_t       e;
      logic       nextDone;
      sAct = {s3Out[d], s2Out[d], s1Out[d]};
      if (reset) begin
        expDone[d] = 1'b0;
        checkOutput("reset_valid", d, 8'(validOut[d]), 8'd0);
        checkOutput("reset_y", d, 8'(yOut[d]), 8'd0);
        checkOutput("reset_done", d, 8'(doneOut[d]), 8'd0);
      end else begin
        checkOutput("valid", d, 8'(validOut[d]), 8'(expQ[d].size() > 0));
        if (expQ[d].size() > 0) begin
          e = expQ[d].pop_front();
          checkOutput("y", d, 8'(yOut[d]), 8'(e.y));
          checkOutput("slot", d, 8'(sAct), 8'(e.s));
          checkOutput("frame_sync", d, 8'(syncOut[d]), 8'(e.sync));
          nextDone = e.last;
        end else begin
          checkOutput("idle_y", d, 8'(yOut[d]), 8'd0);
          checkOutput("idle_slot", d, 8'(sAct), 8'd0);
          checkOutput("idle_sync", d, 8'(syncOut[d]), 8'd0);
          nextDone = 1'b0;
        end
        checkOutput("frame_done", d, 8'(doneOut[d]), 8'(expDone[d]));
        expDone[d] = nextDone;
      end
    end
  end

  initial begin
    int waited;
    reset  = 1'b1;
    enable = 1'b0;
    lines  = 8'h00;
    for (int d = 0; d < 3; d++) expDone[d] = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;

    // single frame, enable pulsed for one cycle
    @(negedge clk) applyStimulus(1'b1, 8'hA5);
    @(negedge clk) applyStimulus(1'b0, 8'hA5);
    repeat (30) @(negedge clk);

    // back-to-back frames with the inputs changing mid-frame
    applyStimulus(1'b1, 8'hFF);
    repeat (12) @(negedge clk);
    applyStimulus(1'b1, 8'h00);
    repeat (40) @(negedge clk);
    applyStimulus(1'b0, 8'h00);
    repeat (30) @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom));
    end
    @(negedge clk) applyStimulus(1'b0, 8'h00);
    repeat (30) @(negedge clk);

    // asynchronous reset in the middle of a frame
    applyStimulus(1'b1, 8'hA5);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput("async_valid", d, 8'(validOut[d]), 8'd0);
      checkOutput("async_y", d, 8'(yOut[d]), 8'd0);
      checkOutput("async_slot", d, 8'({s3Out[d], s2Out[d], s1Out[d]}), 8'd0);
      checkOutput("async_sync", d, 8'(syncOut[d]), 8'd0);
    end
    @(negedge clk) applyStimulus(1'b0, 8'hA5);
    #2 reset = 1'b0;
    repeat (10) @(negedge clk);

    waited = 0;
    while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain", 0, 8'(expQ[0].size() + expQ[1].size() + expQ[2].size()), 8'd0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
